// File: rtl/scratchpad_responder_pkg.sv
// Shared constants for the scratchpad responder: memory function and
// access-type encodings, plus the responder FSM state enum.
package scratchpad_responder_pkg;

  // Memory function: load or store
  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } t_m;

  // Access type: size and extension of the access
  typedef enum logic [2:0] {
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } t_mt;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } t_state;

  function automatic logic mt_is_half(input t_mt typ);
    return (typ == MT_H) || (typ == MT_HU);
  endfunction

  function automatic logic mt_is_word(input t_mt typ);
    return (typ == MT_W) || (typ == MT_WU);
  endfunction

endpackage

// File: rtl/scratchpad_responder_ram.sv
// Single-port 32-bit synchronous storage with per-byte write enables.
// Read data is registered and reflects the addressed word before any
// write issued in the same cycle. Contents are never reset.
module scratchpad_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane masked write and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/scratchpad_responder.sv
// Scratchpad responder: accepts one load/store at a time, answers after a
// fixed LATENCY with a one-cycle resp_valid pulse. Byte-lane steering and
// load extension live here; storage is scratchpad_ram.
// Optional feature macro: SCRATCHPAD_MISALIGN_CHECK_EN (misaligned H/W
// accesses report resp_err instead of being silently aligned).
module scratchpad_responder
  import scratchpad_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  t_m          req_fcn,
  input  t_mt         req_typ,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  t_state        state;
  logic [3:0]    cnt;
  logic          accept;

  logic [AW+1:0] addr_p1;
  logic [31:0]   data_p1;
  t_m            fcn_p1;
  t_mt           typ_p1;

  logic [1:0]    off;
  logic          err;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_rdata;
  logic          unused_addr_hi;

  assign accept         = req_valid && req_ready;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  // Extend the right-aligned load word according to the access type
  function automatic logic [31:0] load_extend(input t_mt typ, input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[7:0];
    h = word[15:0];
    case (typ)
      MT_B:    r = b;
      MT_BU:   r = {24'd0, word[7:0]};
      MT_H:    r = h;
      MT_HU:   r = {16'd0, word[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Control FSM: accept in IDLE, count down in WAIT, pulse in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            cnt        <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= 4'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: request fields captured at accept, held for the access ----
  // Request capture; data path needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= req_addr[AW+1:0];
      data_p1 <= req_data;
      fcn_p1  <= req_fcn;
      typ_p1  <= req_typ;
    end
  end

`ifdef SCRATCHPAD_MISALIGN_CHECK_EN
  assign err = (mt_is_half(typ_p1) && addr_p1[0]) ||
               (mt_is_word(typ_p1) && (addr_p1[1:0] != 2'd0));
  assign off = addr_p1[1:0];
`else
  // Low bits below the access size are dropped rather than flagged
  assign err = 1'b0;
  assign off = mt_is_word(typ_p1) ? 2'd0 :
               mt_is_half(typ_p1) ? {addr_p1[1], 1'b0} : addr_p1[1:0];
`endif

  // Store lane enables and replicated source data for the selected lanes
  always_comb begin
    lane_be    = 4'b0001 << off;
    lane_wdata = {4{data_p1[7:0]}};
    if (mt_is_word(typ_p1)) begin
      lane_be    = 4'b1111;
      lane_wdata = data_p1;
    end else if (mt_is_half(typ_p1)) begin
      lane_be    = off[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{data_p1[15:0]}};
    end
  end

  // In IDLE the RAM reads the incoming address so data is ready for LATENCY=1
  assign ram_addr = (state == ST_IDLE) ? req_addr[AW+1:2] : addr_p1[AW+1:2];
  assign ram_be   = (state == ST_RESP && fcn_p1 == M_XWR && !err) ? lane_be : 4'b0000;

  scratchpad_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(lane_wdata),
    .rdata(ram_rdata)
  );

  // ---- response: outputs gated by the registered resp_valid ----
  assign resp_data = (resp_valid && fcn_p1 == M_XRD && !err)
                   ? load_extend(typ_p1, ram_rdata >> {off, 3'b000}) : 32'd0;
  assign resp_err  = resp_valid && err;

endmodule

// File: tb/tb_scratchpad_responder.sv
// Scoreboard bench for scratchpad_responder: the driver pushes the expected
// response (data, err, arrival cycle) on each accept; a monitor pops and
// compares whenever resp_valid is seen.
module tb_scratchpad_responder;
  import scratchpad_responder_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  t_m          req_fcn = M_XRD;
  t_mt         req_typ = MT_W;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  scratchpad_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_fcn   (req_fcn),
    .req_typ   (req_typ),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Monitor: compare each response against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (resp_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=%08h required=no_response", resp_data);
          end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_data"}, resp_data, mon_e.data);
            check({mon_e.name, "_err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
            check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
          end
        end else begin
          check("idle_data", resp_data, 32'd0);
          check("idle_err", {31'd0, resp_err}, 32'd0);
        end
      end
    end
  end

  // Wait (bounded) for req_ready at a falling edge
  task automatic wait_ready(input string name, output bit ok);
    int w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout actual=0 required=1", name);
    end
  endtask

  // Issue one request and record its expected response
  task automatic issue(input string name, input t_m f, input t_mt t,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee);
    bit   ok;
    exp_t e;
    wait_ready(name, ok);
    if (!ok) return;
    req_fcn   = f;
    req_typ   = t;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    e.name = name;
    e.data = ed;
    e.err  = ee;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    @(negedge clk);
    // Scramble inputs after accept; the in-flight access must not notice
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_fcn   = (req_fcn == M_XRD) ? M_XWR : M_XRD;
    req_typ   = MT_B;
  endtask

  initial begin
    bit   ok;
    exp_t e;
    int   w;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);

    // Basic store/load and extension
    issue("st_w_10",  M_XWR, MT_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    issue("ld_w_10",  M_XRD, MT_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    issue("ld_b_13",  M_XRD, MT_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    issue("ld_bu_13", M_XRD, MT_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
    issue("ld_h_12",  M_XRD, MT_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
    issue("ld_hu_12", M_XRD, MT_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
    issue("st_b_11",  M_XWR, MT_B,  32'h11, 32'hAAAA0055, 32'h0,        1'b0);
    issue("ld_w_10b", M_XRD, MT_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0);
    issue("ld_b_10",  M_XRD, MT_B,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);

    // Halfword store into upper lanes
    issue("st_w_14",  M_XWR, MT_W,  32'h14, 32'h0,        32'h0,        1'b0);
    issue("st_h_16",  M_XWR, MT_H,  32'h16, 32'hA5A58001, 32'h0,        1'b0);
    issue("ld_h_16",  M_XRD, MT_H,  32'h16, 32'h0,        32'hFFFF8001, 1'b0);
    issue("ld_hu_14", M_XRD, MT_HU, 32'h14, 32'h0,        32'h00000000, 1'b0);
    issue("ld_wu_14", M_XRD, MT_WU, 32'h14, 32'h0,        32'h80010000, 1'b0);

    // Address wraps modulo the depth (DEPTH words = 0x400 bytes)
    issue("ld_w_410", M_XRD, MT_W,  32'h410, 32'h0,       32'hDEAD55EF, 1'b0);

    // Held req_valid: one accept every LAT+1 cycles, ready low in between
    wait_ready("held", ok);
    if (ok) begin
      req_fcn   = M_XRD;
      req_typ   = MT_W;
      req_addr  = 32'h10;
      req_valid = 1'b1;
      for (int k = 0; k < 3 * (LAT + 1); k++) begin
        check("held_ready", {31'd0, req_ready}, {31'd0, (k % (LAT + 1)) == 0});
        if ((k % (LAT + 1)) == 0) begin
          e.name = "held_ld";
          e.data = 32'hDEAD55EF;
          e.err  = 1'b0;
          e.cyc  = cyc + LAT;
          sb.push_back(e);
        end
        @(negedge clk);
      end
      req_valid = 1'b0;
    end

    // Reset during an in-flight store drops it
    issue("st_w_20", M_XWR, MT_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    wait_ready("abort", ok);
    if (ok) begin
      req_fcn   = M_XWR;
      req_typ   = MT_W;
      req_addr  = 32'h20;
      req_data  = 32'h12345678;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    end
    issue("ld_w_20_old", M_XRD, MT_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // Misaligned accesses
`ifdef SCRATCHPAD_MISALIGN_CHECK_EN
    issue("st_w_21",  M_XWR, MT_W,  32'h21, 32'h11223344, 32'h0,        1'b1);
    issue("ld_w_20",  M_XRD, MT_W,  32'h20, 32'h0,        32'hCAFEF00D, 1'b0);
    issue("ld_hu_23", M_XRD, MT_HU, 32'h23, 32'h0,        32'h0,        1'b1);
    issue("ld_b_21",  M_XRD, MT_B,  32'h21, 32'h0,        32'hFFFFFFF0, 1'b0);
`else
    issue("st_w_21",  M_XWR, MT_W,  32'h21, 32'h11223344, 32'h0,        1'b0);
    issue("ld_w_20",  M_XRD, MT_W,  32'h20, 32'h0,        32'h11223344, 1'b0);
    issue("ld_hu_23", M_XRD, MT_HU, 32'h23, 32'h0,        32'h00001122, 1'b0);
    issue("ld_b_21",  M_XRD, MT_B,  32'h21, 32'h0,        32'h00000033, 1'b0);
`endif

    // Drain outstanding responses
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/scratchpad_responder.md
SCRATCHPAD_RESPONDER -- requirements
Module: scratchpad_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to response (legal range 1..15).
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1: the requester presents a request.
REQ-006 Port req_ready, output, 1: the responder can accept a request.
REQ-007 Port req_addr, input, 32: byte address.
REQ-008 Port req_data, input, 32: store data, right-aligned.
REQ-009 Port req_fcn, input, t_m: M_XRD (load) or M_XWR (store).
REQ-010 Port req_typ, input, t_mt: MT_B, MT_BU, MT_H, MT_HU, MT_W or MT_WU.
REQ-011 Port resp_valid, output, 1: one-cycle response pulse.
REQ-012 Port resp_data, output, 32: load result, extended per req_typ.
REQ-013 Port resp_err, output, 1: the access was misaligned (config-dependent).

Function
REQ-014 A request SHALL be accepted in the cycle where req_valid and req_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 On accept in IDLE, the FSM SHALL latch addr, data, fcn and typ, then go to RESP if LATENCY=1, otherwise to WAIT.
REQ-018 In WAIT, a down-counter loaded with LATENCY-1 SHALL decrement each cycle, and the FSM SHALL enter RESP when the counter reaches 1.
REQ-019 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Timing: accept in cycle T gives resp_valid in T+LATENCY, and req_ready high again in T+LATENCY+1.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2], so out-of-range addresses wrap modulo the depth.
REQ-022 Stores SHALL update only the byte lanes selected by addr[1:0] and typ: B = 1 lane, H = lanes addr[1]*2..+1, W = all lanes. Source data is the low byte or low half of req_data shifted into those lanes.
REQ-023 The store write SHALL occur in the RESP cycle, and resp_data SHALL be 0 for stores.
REQ-024 Load data SHALL be shifted right by addr[1:0]*8. B and H SHALL sign-extend; BU, HU, W and WU SHALL zero-extend.
REQ-025 Req_valid while not in IDLE SHALL be ignored: no accept and no state change.
REQ-026 Request fields SHALL be sampled only at accept, so later input changes do not affect an in-flight access.
REQ-027 resp_data and resp_err SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.

Reset
REQ-028 On rst=0, the FSM SHALL go to IDLE, the counter to 0, resp_valid, resp_data and resp_err to 0, and req_ready SHALL read 1 after release.
REQ-029 Reset mid-transaction SHALL drop the in-flight access: no response, and a pending store is not written.
REQ-030 Storage contents SHALL NOT be reset.

Configuration
REQ-031 The macro SCRATCHPAD_MISALIGN_CHECK_EN SHALL control misalignment checking.
REQ-032 With SCRATCHPAD_MISALIGN_CHECK_EN defined: a misaligned H/HU (addr[0]=1) or W/WU (addr[1:0]!=0) SHALL set resp_err=1 with the response, suppress any store write, and give resp_data=0.
REQ-033 Without SCRATCHPAD_MISALIGN_CHECK_EN: the ignored low address bits SHALL be cleared (H aligns to 2 bytes, W to 4), and resp_err SHALL be tied to 0.

Structure
REQ-034 t_m, t_mt, M_XRD, M_XWR and the MT_* encodings SHALL come from the shared constants package, and the FSM state enum SHALL be added there.
REQ-035 Storage SHALL be one sub-module, scratchpad_ram: a 1-port, 32-bit, 4-bit byte-enable, synchronous array; all lane and extend logic stays in scratchpad_responder.

Verification
REQ-036 Store MT_W 0xDEADBEEF to addr 0x10, then load MT_W from 0x10: the load gives resp_data=0xDEADBEEF exactly LATENCY cycles after accept.
REQ-037 Load MT_B from 0x13: resp_data=0xFFFFFFDE. Load MT_BU from 0x13: resp_data=0x000000DE. Load MT_H from 0x12: resp_data=0xFFFFDEAD. Load MT_HU from 0x12: resp_data=0x0000DEAD.
REQ-038 Store MT_B 0x55 to 0x11, then load MT_W from 0x10: resp_data=0xDEAD55EF.
REQ-039 Hold req_valid=1 continuously: requests are accepted once every LATENCY+1 cycles, and req_ready=0 during WAIT and RESP.
REQ-040 Accept a store of 0x12345678 to 0x20, assert rst=0 in cycle T+1, release, then load 0x20: there is no resp_valid from the store, and the load returns the old contents.
REQ-041 With SCRATCHPAD_MISALIGN_CHECK_EN, store MT_W to 0x21: resp_err=1 and memory is unchanged. Without it, the same store writes word 0x20 and resp_err=0.
